// File: rtl/pipeline_hazard_ctrl.sv
// EX/MEM sequencing for the 3-stage RV32I core: reset fill, redirect and load-use bubbles, mem_wait freeze.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int          RESET_FILL = 2,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_id,
  input  logic        pc_sel_ex,
  input  logic        mem_wait,
  output logic [31:0] inst_ex,
  output logic [31:0] inst_mem,
  output logic        valid_ex,
  output logic        valid_mem,
  output logic        stall_if,
  output logic        kill_id,
  output logic        pc_redirect,
  output logic [1:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] inst_count
);

  localparam logic [1:0] S_FILL     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int CNT_W = (RESET_FILL > 1) ? $clog2(RESET_FILL) : 1;
  localparam logic [CNT_W-1:0] FILL_INIT = CNT_W'(RESET_FILL - 1);

  logic [CNT_W-1:0] fill_cnt;
  logic [6:0]       op_ex, op_id;
  logic [4:0]       rd_ex, rs1_id, rs2_id;
  logic             rs1_used, rs2_used, load_use, bubble;

  assign op_ex  = inst_ex[6:0];
  assign rd_ex  = inst_ex[11:7];
  assign op_id  = inst_id[6:0];
  assign rs1_id = inst_id[19:15];
  assign rs2_id = inst_id[24:20];

  assign rs1_used = !(op_id == OP_LUI || op_id == OP_AUIPC || op_id == OP_JAL);
  assign rs2_used = (op_id == OP_REG) || (op_id == OP_STORE) || (op_id == OP_BRANCH);

  assign load_use = (state == S_RUN) && valid_ex && (op_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                    ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));

  assign pc_redirect = pc_sel_ex & valid_ex & ~mem_wait;

  // Hazard resolution, highest priority first; outputs settle before the edge they act on
  always_comb begin
    stall_if = 1'b0;
    kill_id  = 1'b0;
    if (rst)                 kill_id  = 1'b1;
    else if (mem_wait)       stall_if = 1'b1;
    else if (pc_redirect)    kill_id  = 1'b1;
    else if (state != S_RUN) kill_id  = 1'b1;
    else if (load_use)       stall_if = 1'b1;
  end

  // Outside mem_wait, stall_if only comes from a load-use hazard, which also needs a bubble
  assign bubble = kill_id | stall_if;

  // ID -> EX -> MEM stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_ex   <= NOP;
      inst_mem  <= NOP;
      valid_ex  <= 1'b0;
      valid_mem <= 1'b0;
    end else if (!mem_wait) begin
      inst_mem  <= inst_ex;
      valid_mem <= valid_ex;
      inst_ex   <= bubble ? NOP : inst_id;
      valid_ex  <= ~bubble;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FILL;
      fill_cnt <= FILL_INIT;
    end else if (!mem_wait) begin
      case (state)
        S_FILL: begin
          if (fill_cnt == '0) state <= S_RUN;
          else                fill_cnt <= fill_cnt - CNT_W'(1);
        end
        S_RUN:      if (pc_redirect) state <= S_REDIRECT;
        S_REDIRECT: state <= S_RUN;
        default:    state <= S_FILL;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (!mem_wait && valid_mem) inst_count <= inst_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
  assign inst_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic.
module tb_pipeline_hazard_ctrl;

  localparam int          RESET_FILL = 2;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_id = NOP;
  logic        pc_sel_ex = 1'b0;
  logic        mem_wait = 1'b0;
  logic [31:0] inst_ex, inst_mem, cycle_count, inst_count;
  logic        valid_ex, valid_mem, stall_if, kill_id, pc_redirect;
  logic [1:0]  state;

  pipeline_hazard_ctrl #(.RESET_FILL(RESET_FILL), .NOP(NOP)) dut (
    .clk(clk), .rst(rst), .inst_id(inst_id), .pc_sel_ex(pc_sel_ex), .mem_wait(mem_wait),
    .inst_ex(inst_ex), .inst_mem(inst_mem), .valid_ex(valid_ex), .valid_mem(valid_mem),
    .stall_if(stall_if), .kill_id(kill_id), .pc_redirect(pc_redirect), .state(state),
    .cycle_count(cycle_count), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ex, mem, cyc, ret;
    logic        vex, vmem, stall, kill, redir;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pipe of (instruction, valid) slots plus remaining-fill and in-redirect markers
  int          fill_left;
  bit          in_redirect;
  logic [31:0] m_ex, m_mem;
  bit          m_vex, m_vmem;
  int unsigned m_cyc, m_ret;
  bit          last_stall;

  task automatic model_reset();
    fill_left   = RESET_FILL;
    in_redirect = 1'b0;
    m_ex = NOP; m_mem = NOP; m_vex = 1'b0; m_vmem = 1'b0;
    m_cyc = 0; m_ret = 0;
  endtask

  function automatic bit load_use_hz(logic [31:0] ex, logic [31:0] id);
    logic [4:0] rd;
    bit r1, r2;
    rd = ex[11:7];
    if (ex[6:0] != 7'h03 || rd == 5'd0) return 1'b0;
    r1 = !(id[6:0] inside {7'h37, 7'h17, 7'h6f});
    r2 = id[6:0] inside {7'h33, 7'h23, 7'h63};
    return (r1 && id[19:15] == rd) || (r2 && id[24:20] == rd);
  endfunction

  task automatic step(input bit r, input logic [31:0] inst, input bit psel, input bit mw);
    exp_t e;
    bit   redir_now, hz, bub;
    redir_now = 1'b0;
    hz = 1'b0;
    @(negedge clk);
    rst = r; inst_id = inst; pc_sel_ex = psel; mem_wait = mw;
    if (r) model_reset();
    e.ex = m_ex; e.mem = m_mem; e.vex = m_vex; e.vmem = m_vmem;
    e.st = (fill_left > 0) ? 2'd0 : (in_redirect ? 2'd2 : 2'd1);
`ifdef PIPE_CTRL_PERF_EN
    e.cyc = m_cyc; e.ret = m_ret;
`else
    e.cyc = 32'd0; e.ret = 32'd0;
`endif
    if (r) begin
      e.stall = 1'b0; e.kill = 1'b1; e.redir = 1'b0;
    end else if (mw) begin
      e.stall = 1'b1; e.kill = 1'b0; e.redir = 1'b0;
    end else begin
      redir_now = psel && m_vex;
      hz = !redir_now && fill_left == 0 && !in_redirect && m_vex && load_use_hz(m_ex, inst);
      e.redir = redir_now;
      e.kill  = redir_now || fill_left > 0 || in_redirect;
      e.stall = hz;
    end
    q.push_back(e);
    last_stall = e.stall;
    if (!r) begin
      m_cyc++;
      if (!mw) begin
        if (m_vmem) m_ret++;
        m_mem = m_ex; m_vmem = m_vex;
        bub = e.kill || e.stall;
        m_ex  = bub ? NOP : inst;
        m_vex = !bub;
        if (fill_left > 0) fill_left--;
        in_redirect = redir_now;
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("inst_ex", inst_ex, e.ex);
        chk("inst_mem", inst_mem, e.mem);
        chk("valid_ex", 32'(valid_ex), 32'(e.vex));
        chk("valid_mem", 32'(valid_mem), 32'(e.vmem));
        chk("stall_if", 32'(stall_if), 32'(e.stall));
        chk("kill_id", 32'(kill_id), 32'(e.kill));
        chk("pc_redirect", 32'(pc_redirect), 32'(e.redir));
        chk("state", 32'(state), 32'(e.st));
        chk("cycle_count", cycle_count, e.cyc);
        chk("inst_count", inst_count, e.ret);
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    case ($urandom_range(0, 8))
      0: op = 7'h03;  1: op = 7'h03;  2: op = 7'h33;
      3: op = 7'h13;  4: op = 7'h23;  5: op = 7'h63;
      6: op = 7'h37;  7: op = 7'h17;  default: op = 7'h6f;
    endcase
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    return {7'd0, rs2, rs1, 3'b010, rd, op};
  endfunction

  initial begin : stimulus
    logic [31:0] cur;
    model_reset();
    last_stall = 1'b0;
    step(1, NOP, 0, 0);
    step(1, NOP, 0, 0);
    // Reset fill with a fixed ID instruction
    repeat (4) step(0, 32'h0010_0093, 0, 0);
    // Load-use, then a load followed by a reader of x0
    step(0, 32'h0000_A103, 0, 0);
    step(0, 32'h0020_81B3, 0, 0);
    step(0, 32'h0020_81B3, 0, 0);
    step(0, 32'h0000_A103, 0, 0);
    step(0, 32'h0010_0193, 0, 0);
    step(0, NOP, 0, 0);
    // Taken branch: two bubbles then the target
    step(0, 32'h0020_0093, 1, 0);
    step(0, 32'h0030_0093, 0, 0);
    step(0, 32'h0040_0093, 0, 0);
    step(0, NOP, 0, 0);
    // mem_wait overlapping a redirect and a load-use hazard
    step(0, 32'h0000_A103, 0, 0);
    repeat (3) step(0, 32'h0020_81B3, 1, 1);
    step(0, 32'h0020_81B3, 1, 0);
    // Asynchronous reset while in REDIRECT
    step(1, 32'h0050_0093, 0, 0);
    step(1, NOP, 0, 0);
    // Straight-line run with a single load-use stall
    step(0, 32'h0000_A103, 0, 0);
    step(0, 32'h0000_A103, 0, 0);
    step(0, 32'h0000_A103, 0, 0);
    step(0, 32'h0020_81B3, 0, 0);
    step(0, 32'h0020_81B3, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0010_0093 + (i << 7), 0, 0);
    repeat (4) step(0, NOP, 0, 0);
    // Random traffic
    cur = rand_inst();
    for (int i = 0; i < 600; i++) begin
      if (!last_stall) cur = rand_inst();
      step(($urandom_range(0, 99) == 0), cur,
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end
    repeat (3) @(negedge clk);
    #4;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
